// File: rtl/fe_capture_queued_pkg.sv
// Shared FIFO command codes and PHY status bit positions for the front-end capture engine.
package fe_capture_queued_pkg;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

    localparam int FE_FIFO_STATUS_BITS_LEN = 5;

    localparam int FE_STATUS_RXACTIVE = 0;
    localparam int FE_STATUS_RXERROR  = 1;
    localparam int FE_STATUS_SESSVLD  = 2;
    localparam int FE_STATUS_SESSEND  = 3;
    localparam int FE_STATUS_VBUSVLD  = 4;

    function automatic logic is_payload_cmd(input logic [1:0] cmd);
        return (cmd == FE_FIFO_CMD_DATA) || (cmd == FE_FIFO_CMD_STAT);
    endfunction

endpackage

// File: rtl/fe_capture_queued_event_queue.sv
// fe_event_queue: small synchronous FIFO holding pending capture events {kind, data, status, gap}.
module fe_event_queue #(
    parameter int pWIDTH = 32,
    parameter int pDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [pWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [pWIDTH-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(pDEPTH);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset_i || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fe_capture_queued.sv
// fe_capture_queued: turns PHY rx bytes and masked status changes into timestamped DATA/STAT/TIME records.
// Build option FE_CAPTURE_DROP_COUNT_EN adds the O_drop_count port.
module fe_capture_queued
    import fe_capture_queued_pkg::*;
#(
    parameter int pDATA_WIDTH            = 8,
    parameter int pSTATUS_WIDTH          = FE_FIFO_STATUS_BITS_LEN,
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pQUEUE_DEPTH           = 4,
    parameter int pCOUNT_WIDTH           = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic [pDATA_WIDTH-1:0]           fe_data,
    input  logic                             fe_rxvalid,
    input  logic [pSTATUS_WIDTH-1:0]         fe_status,
    input  logic [pSTATUS_WIDTH-1:0]         I_status_mask,
    input  logic                             I_timestamps_disable,
    input  logic                             I_arm,
    input  logic                             I_capture_enable,
    input  logic [pCOUNT_WIDTH-1:0]          I_capture_len,
    input  logic                             I_fifo_full,
    output logic [1:0]                       O_command,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_time,
    output logic [pDATA_WIDTH-1:0]           O_data,
    output logic [pSTATUS_WIDTH-1:0]         O_status,
    output logic                             O_data_wr,
    output logic [pDATA_WIDTH-1:0]           O_sniff_data,
    output logic                             O_sniff_wr,
    output logic                             O_capturing,
    output logic                             O_done,
    output logic                             O_overrun
`ifdef FE_CAPTURE_DROP_COUNT_EN
    ,
    output logic [15:0]                      O_drop_count
`endif
);
    localparam int TSW     = pTIMESTAMP_FULL_WIDTH;
    localparam int ENTRY_W = 2 + pDATA_WIDTH + pSTATUS_WIDTH + TSW;
    localparam logic [TSW-1:0] GAP_MAX     = {TSW{1'b1}};
    localparam logic [TSW-1:0] SHORT_LIMIT = TSW'(1) << pTIMESTAMP_SHORT_WIDTH;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REC  = 1'b1;

    logic [pDATA_WIDTH-1:0]   r_data_p1;
    logic                     r_rxvalid_p1;
    logic [pSTATUS_WIDTH-1:0] r_status_p1;
    logic [pSTATUS_WIDTH-1:0] r_status_p2;
    logic                     r_arm_d;
    logic [TSW-1:0]           r_gap;
    logic                     r_gap_run;
    logic [pCOUNT_WIDTH-1:0]  r_count;
    logic [0:0]               r_state;

    logic                     w_arm_rise;
    logic                     w_event;
    logic                     w_wrap;
    logic                     w_allowed;
    logic                     w_push_req;
    logic                     w_push;
    logic                     w_drop;
    logic [1:0]               w_kind;
    logic [TSW-1:0]           w_ev_gap;
    logic [ENTRY_W-1:0]       w_push_entry;
    logic [ENTRY_W-1:0]       w_head;
    logic                     w_full;
    logic                     w_empty;
    logic [1:0]               w_head_kind;
    logic [pDATA_WIDTH-1:0]   w_head_data;
    logic [pSTATUS_WIDTH-1:0] w_head_status;
    logic [TSW-1:0]           w_head_gap;
    logic [pCOUNT_WIDTH-1:0]  w_count_inc;
    logic                     w_pop;
    logic                     w_wr;
    logic [1:0]               w_cmd;
    logic [TSW-1:0]           w_time;
    logic [0:0]               w_state_nxt;

    // Stage 1: register PHY pins; the second status copy exposes bit changes.
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_data_p1    <= '0;
            r_rxvalid_p1 <= 1'b0;
            r_status_p1  <= '0;
            r_status_p2  <= '0;
            r_arm_d      <= 1'b0;
        end else begin
            r_data_p1    <= fe_data;
            r_rxvalid_p1 <= fe_rxvalid;
            r_status_p1  <= fe_status;
            r_status_p2  <= r_status_p1;
            r_arm_d      <= I_arm;
        end
    end

    assign O_sniff_data = r_data_p1;
    assign O_sniff_wr   = r_rxvalid_p1;

    assign w_arm_rise = I_arm & ~r_arm_d;
    assign w_event    = r_rxvalid_p1 | (|((r_status_p1 ^ r_status_p2) & I_status_mask));
    assign w_kind     = r_rxvalid_p1 ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
    assign w_ev_gap   = I_timestamps_disable ? '0 : r_gap;
    assign w_wrap     = r_gap_run & ~w_event & ~I_timestamps_disable & (r_gap == GAP_MAX);
    assign w_allowed  = I_capture_enable & ((I_capture_len == '0) | (r_count < I_capture_len));
    assign O_capturing = w_allowed;

    // Stage 2: enqueue an event, or a TIME-only entry when the gap counter saturates.
    assign w_push_req   = ~w_arm_rise & w_allowed & (w_event | w_wrap);
    assign w_push       = w_push_req & ~w_full;
    assign w_drop       = w_push_req & w_full;
    assign w_push_entry = w_event ? {w_kind, r_data_p1, r_status_p1, w_ev_gap}
                                  : {FE_FIFO_CMD_TIME, {pDATA_WIDTH{1'b0}}, {pSTATUS_WIDTH{1'b0}}, GAP_MAX};

    always_ff @(posedge fe_clk) begin
        if (reset_i || w_arm_rise) begin
            r_gap     <= '0;
            r_gap_run <= 1'b0;
        end else if (w_event) begin
            r_gap     <= '0;
            r_gap_run <= r_gap_run | w_allowed;
        end else if (r_gap_run) begin
            if (I_timestamps_disable || r_gap == GAP_MAX) r_gap <= '0;
            else                                          r_gap <= r_gap + TSW'(1);
        end
    end

    fe_event_queue #(
        .pWIDTH (ENTRY_W),
        .pDEPTH (pQUEUE_DEPTH)
    ) u_queue (
        .clk     (fe_clk),
        .reset_i (reset_i),
        .i_clear (w_arm_rise),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_kind   = w_head[ENTRY_W-1 -: 2];
    assign w_head_data   = w_head[pSTATUS_WIDTH+TSW +: pDATA_WIDTH];
    assign w_head_status = w_head[TSW +: pSTATUS_WIDTH];
    assign w_head_gap    = w_head[TSW-1:0];
    assign w_count_inc   = r_count + pCOUNT_WIDTH'(1);

    // Stage 3: drain one record per cycle; entries left after the length limit are discarded unwritten.
    always_comb begin
        w_pop       = 1'b0;
        w_wr        = 1'b0;
        w_cmd       = w_head_kind;
        w_time      = w_head_gap;
        w_state_nxt = r_state;
        if (!w_empty && !I_fifo_full) begin
            if (O_done) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if (r_state == ST_REC) begin
                w_pop       = 1'b1;
                w_wr        = 1'b1;
                w_time      = '0;
                w_state_nxt = ST_IDLE;
            end else if (!is_payload_cmd(w_head_kind)) begin
                w_pop = 1'b1;
                w_wr  = 1'b1;
            end else if (!I_timestamps_disable && w_head_gap >= SHORT_LIMIT) begin
                w_wr        = 1'b1;
                w_cmd       = FE_FIFO_CMD_TIME;
                w_state_nxt = ST_REC;
            end else begin
                w_pop = 1'b1;
                w_wr  = 1'b1;
            end
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            O_data_wr <= 1'b0;
            O_command <= '0;
            O_time    <= '0;
            O_data    <= '0;
            O_status  <= '0;
            O_done    <= 1'b0;
            O_overrun <= 1'b0;
        end else if (w_arm_rise) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            O_data_wr <= 1'b0;
            O_done    <= 1'b0;
            O_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            O_data_wr <= w_wr;
            if (w_wr) begin
                O_command <= w_cmd;
                O_time    <= w_time;
                O_data    <= w_head_data;
                O_status  <= w_head_status;
                r_count   <= w_count_inc;
                if (I_capture_len != '0 && w_count_inc == I_capture_len) O_done <= 1'b1;
            end
            if (w_drop) O_overrun <= 1'b1;
        end
    end

`ifdef FE_CAPTURE_DROP_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge fe_clk) begin
        if (reset_i || w_arm_rise) O_drop_count <= '0;
        else if (w_drop)           O_drop_count <= sat_inc16(O_drop_count);
    end
`endif

endmodule

// File: tb/tb_fe_capture_queued.sv
// Scoreboard bench for fe_capture_queued: expected records queued at stimulus, matched against O_data_wr records.
module tb_fe_capture_queued;
    import fe_capture_queued_pkg::*;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] t;
        logic [7:0]  d;
        logic [4:0]  s;
    } rec_t;

    logic        fe_clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  fe_data = '0;
    logic        fe_rxvalid = 1'b0;
    logic [4:0]  fe_status = '0;
    logic [4:0]  I_status_mask = 5'b11111;
    logic        I_timestamps_disable = 1'b0;
    logic        I_arm = 1'b0;
    logic        I_capture_enable = 1'b0;
    logic [15:0] I_capture_len = '0;
    logic        I_fifo_full = 1'b0;
    logic [1:0]  O_command;
    logic [15:0] O_time;
    logic [7:0]  O_data;
    logic [4:0]  O_status;
    logic        O_data_wr;
    logic [7:0]  O_sniff_data;
    logic        O_sniff_wr;
    logic        O_capturing;
    logic        O_done;
    logic        O_overrun;
`ifdef FE_CAPTURE_DROP_COUNT_EN
    logic [15:0] O_drop_count;
`endif

    fe_capture_queued dut (
        .fe_clk               (fe_clk),
        .reset_i              (reset_i),
        .fe_data              (fe_data),
        .fe_rxvalid           (fe_rxvalid),
        .fe_status            (fe_status),
        .I_status_mask        (I_status_mask),
        .I_timestamps_disable (I_timestamps_disable),
        .I_arm                (I_arm),
        .I_capture_enable     (I_capture_enable),
        .I_capture_len        (I_capture_len),
        .I_fifo_full          (I_fifo_full),
        .O_command            (O_command),
        .O_time               (O_time),
        .O_data               (O_data),
        .O_status             (O_status),
        .O_data_wr            (O_data_wr),
        .O_sniff_data         (O_sniff_data),
        .O_sniff_wr           (O_sniff_wr),
        .O_capturing          (O_capturing),
        .O_done               (O_done),
        .O_overrun            (O_overrun)
`ifdef FE_CAPTURE_DROP_COUNT_EN
        ,
        .O_drop_count         (O_drop_count)
`endif
    );

    always #5 fe_clk = ~fe_clk;

    rec_t sb[$];
    rec_t obs[$];
    int   obs_rd = 0;
    int   wr_count = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(negedge fe_clk) begin
        if (O_data_wr === 1'b1) begin
            obs.push_back('{O_command, O_time, O_data, O_status});
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic expect_rec(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d, input logic [4:0] s);
        sb.push_back('{c, t, d, s});
    endtask

    task automatic arm();
        I_arm = 1'b1;
        tick();
        I_arm = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        fe_data    = d;
        fe_rxvalid = 1'b1;
        tick();
        fe_rxvalid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        rec_t e;
        rec_t o;
        int n = 0;
        while ((obs.size() - obs_rd) < sb.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (5) tick();
        while (obs_rd < obs.size()) begin
            o = obs[obs_rd];
            obs_rd++;
            if (sb.size() == 0) begin
                check({tag, "_extra_wr"}, 32'(o.cmd), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check({tag, "_cmd"}, 32'(o.cmd), 32'(e.cmd));
                check({tag, "_time"}, 32'(o.t), 32'(e.t));
                if (e.cmd != FE_FIFO_CMD_TIME) begin
                    check({tag, "_data"}, 32'(o.d), 32'(e.d));
                    check({tag, "_status"}, 32'(o.s), 32'(e.s));
                end
            end
        end
        check({tag, "_missing"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int w0;

        repeat (4) tick();
        check("rst_wr", 32'(O_data_wr), 32'd0);
        check("rst_cmd", 32'(O_command), 32'd0);
        check("rst_time", 32'(O_time), 32'd0);
        check("rst_done", 32'(O_done), 32'd0);
        check("rst_overrun", 32'(O_overrun), 32'd0);
        check("rst_capturing", 32'(O_capturing), 32'd0);
        check("rst_sniff_wr", 32'(O_sniff_wr), 32'd0);
        reset_i = 1'b0;
        I_capture_enable = 1'b1;
        tick();

        // Gap of 100 idle cycles ahead of three back-to-back bytes; also first-record latency.
        arm();
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hA0, 5'd0);
        fe_data = 8'hA0;
        fe_rxvalid = 1'b1;
        tick();
        fe_rxvalid = 1'b0;
        check("sniff_wr", 32'(O_sniff_wr), 32'd1);
        tick();
        check("lat_cycle2_wr", 32'(O_data_wr), 32'd0);
        tick();
        check("lat_cycle3_wr", 32'(O_data_wr), 32'd1);
        repeat (98) tick();
        expect_rec(FE_FIFO_CMD_TIME, 16'd100, 8'h00, 5'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hB1, 5'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hB2, 5'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hB3, 5'd0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        drain("gap100", 50);
        check("gap100_overrun", 32'(O_overrun), 32'd0);

        // Only masked status bits raise STAT events.
        arm();
        I_status_mask = 5'b00001;
        fe_data = 8'h5A;
        fe_status = 5'b00010;
        repeat (4) tick();
        expect_rec(FE_FIFO_CMD_STAT, 16'd0, 8'h5A, 5'b00011);
        fe_status = 5'b00011;
        tick();
        drain("mask", 30);
        I_status_mask = 5'b00000;
        fe_status = 5'b00000;
        repeat (4) tick();
        I_status_mask = 5'b11111;

        // Capture length limit of 4 over 10 bytes.
        I_capture_len = 16'd4;
        arm();
        w0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'(8'hC0 + i), 5'd0);
            send_byte(8'(8'hC0 + i));
        end
        drain("len4", 40);
        check("len4_writes", 32'(wr_count - w0), 32'd4);
        check("len4_done", 32'(O_done), 32'd1);
        check("len4_capturing", 32'(O_capturing), 32'd0);
        I_capture_len = 16'd0;

        // FIFO full for 20 cycles across 6 events: 4 queued, 2 dropped.
        arm();
        check("arm_clears_done", 32'(O_done), 32'd0);
        I_fifo_full = 1'b1;
        w0 = wr_count;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'(8'hD0 + i), 5'd0);
            send_byte(8'(8'hD0 + i));
        end
        repeat (14) tick();
        check("full_no_wr", 32'(wr_count - w0), 32'd0);
        check("full_overrun", 32'(O_overrun), 32'd1);
`ifdef FE_CAPTURE_DROP_COUNT_EN
        check("full_drop_count", 32'(O_drop_count), 32'd2);
`endif
        I_fifo_full = 1'b0;
        drain("full", 40);
        check("full_writes", 32'(wr_count - w0), 32'd4);

        // Arm edge while the TIME record of a long-gap byte is on the outputs.
        arm();
        check("arm_clears_overrun", 32'(O_overrun), 32'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hE0, 5'd0);
        send_byte(8'hE0);
        repeat (20) tick();
        expect_rec(FE_FIFO_CMD_TIME, 16'd20, 8'h00, 5'd0);
        send_byte(8'hE1);
        tick();
        tick();
        check("abort_time_wr", 32'(O_data_wr), 32'd1);
        check("abort_time_cmd", 32'(O_command), 32'(FE_FIFO_CMD_TIME));
        I_arm = 1'b1;
        tick();
        I_arm = 1'b0;
        check("abort_wr_low", 32'(O_data_wr), 32'd0);
        drain("abort", 30);

        // Timestamps disabled: long gap yields no TIME record and time 0.
        arm();
        I_timestamps_disable = 1'b1;
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hF0, 5'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'hF1, 5'd0);
        send_byte(8'hF0);
        repeat (30) tick();
        send_byte(8'hF1);
        drain("tsdis", 30);
        I_timestamps_disable = 1'b0;

        // 70000 idle cycles: saturated TIME record, then remaining gap 4464.
        arm();
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'h11, 5'd0);
        send_byte(8'h11);
        repeat (70000) tick();
        expect_rec(FE_FIFO_CMD_TIME, 16'hFFFF, 8'h00, 5'd0);
        expect_rec(FE_FIFO_CMD_TIME, 16'd4464, 8'h00, 5'd0);
        expect_rec(FE_FIFO_CMD_DATA, 16'd0, 8'h22, 5'd0);
        send_byte(8'h22);
        drain("wrap", 40);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
